// File: rtl/wb_ram_secondary.sv
// Wishbone classic secondary: single-beat, byte-writable on-chip RAM with a
// configurable wait-state count and error termination for bad address or empty select.
module wb_ram_secondary #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);
    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdat_q, wdat_d;
    logic          bad_q, bad_d;
    logic [31:0]   rdat_q, rdat_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic [31:0]   off;
    logic          bad;
    logic          acc_go;
    logic          acc_we;
    logic [3:0]    acc_sel;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_dat;
    logic          mem_wr;

    // The full 32-bit offset takes part in the range test, so wrap-around below BASE_ADDR is rejected too.
    assign req = wb_cyc_i & wb_stb_i;
    assign off = wb_adr_i - BASE_ADDR;
    assign bad = ({1'b0, off} >= LIMIT) || (wb_sel_i == 4'b0000);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        bad_d   = bad_q;
        rdat_d  = rdat_q;
        acc_go  = 1'b0;
        acc_we  = we_q;
        acc_sel = sel_q;
        acc_idx = idx_q;
        acc_dat = wdat_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d   = wb_we_i;
                    sel_d  = wb_sel_i;
                    idx_d  = off[AW+1:2];
                    wdat_d = wb_dat_i;
                    bad_d  = bad;
                    cnt_d  = CNT_INIT;
                    if (WAIT_STATES == 0) begin
                        if (bad) begin
                            state_d = ERR;
                        end else begin
                            // Zero wait states: the access uses the live bus values directly.
                            state_d = ACK;
                            acc_go  = 1'b1;
                            acc_we  = wb_we_i;
                            acc_sel = wb_sel_i;
                            acc_idx = off[AW+1:2];
                            acc_dat = wb_dat_i;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    if (bad_q) begin
                        state_d = ERR;
                    end else begin
                        state_d = ACK;
                        acc_go  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK, ERR: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        mem_wr = acc_go & acc_we;
        if (acc_go && !acc_we) begin
            rdat_d = mem[acc_idx];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            idx_q   <= '0;
            wdat_q  <= 32'h0;
            bad_q   <= 1'b0;
            rdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            bad_q   <= bad_d;
            rdat_q  <= rdat_d;
        end
    end

    // RAM contents survive reset; a write is suppressed while reset is held.
    always_ff @(posedge wb_clk_i) begin
        if (mem_wr && !wb_rst_i) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_sel[k]) begin
                    mem[acc_idx][8*k +: 8] <= acc_dat[8*k +: 8];
                end
            end
        end
    end

    assign wb_dat_o = rdat_q;
    assign wb_ack_o = (state_q == ACK);
    assign wb_err_o = (state_q == ERR);

endmodule

// File: tb/tb_wb_ram_secondary.sv
// Scoreboard bench for wb_ram_secondary: three instances (0, 1 and 3 wait states)
// driven with directed and random single-beat transfers against an array model.
module tb_wb_ram_secondary;
    localparam int N     = 3;
    localparam int DEPTH = 16;

    typedef struct {
        int          tgt;
        bit          is_err;
        logic [31:0] dat;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    int          tgt = 0;

    logic [N-1:0] cyc_w;
    logic [31:0]  dat_w [N];
    logic         ack_w [N];
    logic         err_w [N];

    logic [31:0] model_mem [N][DEPTH];
    logic [31:0] last_rd [N];
    exp_t        sb [$];
    longint      cycle = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign cyc_w[0] = cyc && (tgt == 0);
    assign cyc_w[1] = cyc && (tgt == 1);
    assign cyc_w[2] = cyc && (tgt == 2);

    wb_ram_secondary #(.BASE_ADDR(32'h8000_0040), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc_w[0]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_dat_o(dat_w[0]), .wb_ack_o(ack_w[0]), .wb_err_o(err_w[0]));

    wb_ram_secondary #(.BASE_ADDR(32'h0000_1000), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc_w[1]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_dat_o(dat_w[1]), .wb_ack_o(ack_w[1]), .wb_err_o(err_w[1]));

    wb_ram_secondary #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc_w[2]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_dat_o(dat_w[2]), .wb_ack_o(ack_w[2]), .wb_err_o(err_w[2]));

    function automatic logic [31:0] base_of(input int t);
        case (t)
            0:       return 32'h8000_0040;
            1:       return 32'h0000_1000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic int ws_of(input int t);
        case (t)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // The model works from addresses and byte lanes only; the primary sees the
    // termination on edge N+1+WAIT_STATES when the request was sampled on edge N.
    task automatic applyStimulus(input int t, input bit w, input logic [31:0] a,
                                 input logic [3:0] s, input logic [31:0] d);
        exp_t        e;
        logic [31:0] o;
        int          idx;
        bit          ok;
        bit          done;
        o   = a - base_of(t);
        ok  = (o < 32'(DEPTH * 4)) && (s != 4'h0);
        idx = int'(o >> 2) % DEPTH;
        if (ok && w) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) model_mem[t][idx][8*k +: 8] = d[8*k +: 8];
        end else if (ok) begin
            last_rd[t] = model_mem[t][idx];
        end
        @(negedge clk);
        #1;
        tgt = t; we = w; adr = a; sel = s; wdat = d;
        cyc = 1'b1; stb = 1'b1;
        e.tgt = t; e.is_err = !ok; e.dat = last_rd[t];
        e.due = cycle + 1 + ws_of(t);
        sb.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checkOutput("bus_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int t = 0; t < N; t++) begin
                    if (ack_w[t] && err_w[t])
                        checkOutput($sformatf("ack_err_exclusive_dut%0d", t), {30'h0, ack_w[t], err_w[t]}, 32'h2);
                    if (ack_w[t] || err_w[t]) begin
                        if (sb.size() == 0 || sb[0].tgt != t) begin
                            checkOutput($sformatf("unexpected_termination_dut%0d", t),
                                        {30'h0, err_w[t], ack_w[t]}, 32'h0);
                        end else begin
                            e = sb.pop_front();
                            checkOutput($sformatf("err_flag_dut%0d", t), {31'h0, err_w[t]}, {31'h0, e.is_err});
                            checkOutput($sformatf("dat_o_dut%0d", t), dat_w[t], e.dat);
                            checkOutput($sformatf("latency_dut%0d", t), 32'(cycle), 32'(e.due));
                        end
                    end
                end
                if (sb.size() != 0 && cycle > sb[0].due) begin
                    checkOutput("response_missing", 32'(cycle), 32'(sb[0].due));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        for (int t = 0; t < N; t++) begin
            checkOutput($sformatf("%s_ack_dut%0d", tag, t), {31'h0, ack_w[t]}, 32'h0);
            checkOutput($sformatf("%s_err_dut%0d", tag, t), {31'h0, err_w[t]}, 32'h0);
            checkOutput($sformatf("%s_dat_dut%0d", tag, t), dat_w[t], 32'h0);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        logic [31:0] a;
        logic [31:0] o;
        int          t;
        int          pick;

        for (int i = 0; i < N; i++) last_rd[i] = 32'h0;

        #2 rst = 1'b1;
        #1 checkResetOutputs("reset_immediate");
        repeat (3) @(negedge clk);
        checkResetOutputs("reset_held");
        #1 rst = 1'b0;

        for (int i = 0; i < N; i++)
            for (int j = 0; j < DEPTH; j++)
                applyStimulus(i, 1'b1, base_of(i) + 32'(4 * j), 4'hF, $urandom);

        $display("[TB] directed word and byte-lane tests");
        applyStimulus(1, 1'b1, base_of(1) + 32'h10, 4'hF, 32'hDEADBEEF);
        applyStimulus(1, 1'b0, base_of(1) + 32'h10, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, base_of(1) + 32'h10, 4'b0010, 32'h0000AA00);
        applyStimulus(1, 1'b0, base_of(1) + 32'h10, 4'h1, 32'h0);
        applyStimulus(1, 1'b0, base_of(1) + 32'(4 * DEPTH), 4'hF, 32'h0);
        applyStimulus(1, 1'b1, base_of(1) + 32'h10, 4'h0, 32'hFFFFFFFF);
        applyStimulus(1, 1'b0, base_of(1) + 32'h10, 4'hF, 32'h0);
        applyStimulus(0, 1'b0, base_of(0) + 32'(4 * DEPTH), 4'hF, 32'h0);
        applyStimulus(0, 1'b0, base_of(0) - 32'h4, 4'hF, 32'h0);
        applyStimulus(2, 1'b0, base_of(2) + 32'(4 * DEPTH - 4), 4'hF, 32'h0);

        $display("[TB] abort during wait states");
        @(negedge clk);
        #1;
        tgt = 2; we = 1'b1; adr = base_of(2) + 32'h8; sel = 4'hF; wdat = 32'h12345678;
        cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 cyc = 1'b0; stb = 1'b0;
        repeat (8) @(negedge clk);
        applyStimulus(2, 1'b0, base_of(2) + 32'h8, 4'hF, 32'h0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 150; n++) begin
            t    = $urandom_range(0, N - 1);
            pick = $urandom_range(0, 9);
            if (pick == 0)      o = 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
            else if (pick == 1) o = 32'h0 - 32'(4 * $urandom_range(1, 4));
            else                o = 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            a = base_of(t) + o;
            applyStimulus(t, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < N; i++)
            applyStimulus(i, 1'b0, base_of(i) + 32'h4, 4'hF, 32'h0);

        $display("[TB] asynchronous reset during wait states");
        @(negedge clk);
        #1;
        tgt = 2; we = 1'b1; adr = base_of(2) + 32'h4; sel = 4'hF; wdat = 32'hCAFEF00D;
        cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        #3 rst = 1'b1;
        #1 checkResetOutputs("reset_mid_wait");
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < N; i++) last_rd[i] = 32'h0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset_mid_wait_held");
        #1 rst = 1'b0;
        applyStimulus(2, 1'b0, base_of(2) + 32'h4, 4'hF, 32'h0);
        applyStimulus(1, 1'b0, base_of(1) + 32'h10, 4'hF, 32'h0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
